// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the latency-configurable register controller:
// FSM encoding, strobe sizing and legal read-latency bounds.
package reg_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 8;

    function automatic int strb_count(input int data_width);
        return data_width / 8;
    endfunction

    function automatic bit latency_legal(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/reg_ctrl_lat_wmerge.sv
// Byte-strobe merge: each enabled byte lane takes wdata, the rest keep cur.
module reg_ctrl_lat_wmerge
    import reg_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]             cur,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [strb_count(DATA_WIDTH)-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]             merged
);

    localparam int STRB_W = strb_count(DATA_WIDTH);

    always_comb begin
        merged = cur;
        for (int i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/reg_ctrl_lat.sv
// DEPTH-entry register bank with byte-strobed writes, a configurable read
// latency signalled by an rvalid pulse, and an err pulse for out-of-range access.
module reg_ctrl_lat
    import reg_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    DEPTH        = 256,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL    = 16'h1234,
    parameter int                    READ_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sel,
    input  logic                              wr,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [strb_count(DATA_WIDTH)-1:0] wstrb,
    output logic                              ready,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              rvalid,
    output logic                              err
);

    localparam int CNT_W = $clog2(READ_LATENCY) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);

    if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("reg_ctrl_lat: READ_LATENCY out of range");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("reg_ctrl_lat: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("reg_ctrl_lat: DEPTH exceeds address space");
    end

    state_t                 state, state_n;
    logic [CNT_W-1:0]       count, count_n;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  cur, merged;
    logic [DATA_WIDTH-1:0]  snap_data_p0;
    logic                   snap_err_p0;
    logic [IDX_W-1:0]       idx;
    logic                   in_range;
    logic                   acc, rd_acc, wr_acc, rd_done;

    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign idx      = addr[IDX_W-1:0];
    assign cur      = mem[idx];

    assign acc    = sel && ready;
    assign rd_acc = acc && !wr;
    assign wr_acc = acc && wr;

    reg_ctrl_lat_wmerge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wmerge (
        .cur    (cur),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .merged (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        case (state)
            IDLE: begin
                if (rd_acc) begin
                    state_n = RD_WAIT;
                    count_n = CNT_LOAD;
                end
            end
            RD_WAIT: begin
                if (count != '0) begin
                    count_n = count - 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    // ready is a pure function of state, so it rises in the rvalid cycle
    always_comb begin
        ready   = (state == IDLE);
        rd_done = (state == RD_WAIT) && (count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (wr_acc && in_range) begin
            mem[idx] <= merged;
        end
    end

    // stage p0: read snapshot taken at accept
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            snap_data_p0 <= in_range ? cur : '0;
            snap_err_p0  <= !in_range;
        end
    end

    // completion: rdata/rvalid/err presented after the latency expires
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= rd_done;
            err    <= (wr_acc && !in_range) || (rd_done && snap_err_p0);
            if (rd_done) begin
                rdata <= snap_data_p0;
            end
        end
    end

endmodule

// File: doc/reg_ctrl_lat.md
Name: reg_ctrl_lat

Overview:
- Parametrised successor to the single-cycle register controller: a DEPTH-entry register bank with one request port (sel/wr/addr) and per-byte write strobes.
- Read latency is configurable; completion is signalled by an rvalid pulse.
- Out-of-range accesses raise an err pulse.
- Sits between a bus/CPU-side master and block-local configuration registers; ready provides back-pressure while a read is in flight.

Parameters:
- ADDR_WIDTH, 8, address bits.
- DATA_WIDTH, 16, register width; must be a multiple of 8.
- DEPTH, 256, number of registers; must be ≤ 2**ADDR_WIDTH.
- RESET_VAL, 16'h1234, reset contents of every register.
- READ_LATENCY, 2, number of clock edges from read accept to rvalid; legal range 1..8.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- sel  in  1  request valid.
- wr  in  1  1 = write, 0 = read; qualified by sel.
- addr  in  ADDR_WIDTH  register index.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables; bit i enables wdata[8i+7:8i].
- ready  out  1  high = a request can be accepted this cycle.
- rdata  out  DATA_WIDTH  read data; valid when rvalid is high, held until the next read completes.
- rvalid  out  1  one-cycle pulse when a read completes.
- err  out  1  one-cycle pulse for an out-of-range access (addr ≥ DEPTH).

Behaviour:
- Reset (rst=1 at a clock edge):
  - all DEPTH entries = RESET_VAL; state = IDLE; counter = 0.
  - ready = 1, rdata = 0, rvalid = 0, err = 0.
  - Reset mid-read aborts the read; no rvalid is produced.
- Accept: a request is accepted at edge E0 when sel && ready. If sel is high while ready is low, the request is ignored silently: no error, no queueing.
- Write accept:
  - For each i with wstrb[i] = 1, entry[addr] byte i <= wdata byte i at E0; other bytes keep their value.
  - wstrb = 0 is a legal no-op.
  - ready stays 1, so back-to-back writes are allowed every cycle.
  - A read accepted at the next edge returns the new value.
- Read accept:
  - entry[addr] is snapshotted at E0.
  - State goes to RD_WAIT and counter <= READ_LATENCY-1.
  - ready = 0 throughout RD_WAIT, i.e. for exactly READ_LATENCY cycles.
- FSM IDLE → RD_WAIT: on an accepted read.
- In RD_WAIT: if counter != 0, decrement; at the edge where counter == 0:
  - state returns to IDLE;
  - rdata <= snapshot;
  - rvalid <= 1 for one cycle.
- ready returns to 1 in the same cycle rvalid is high, so a new request may be accepted on that edge.
- Out of range (addr ≥ DEPTH):
  - Write: storage is unchanged; err pulses in the cycle after E0.
  - Read: the full latency is still observed; rdata <= 0; err and rvalid pulse together.
- rdata is unchanged by writes, by ignored requests and by err-only events.
- Width rules:
  - addr is compared unsigned against DEPTH.
  - The counter is clog2(READ_LATENCY)+1 bits wide (minimum 1); it never wraps below 0.

Decomposition:
- Shared package reg_ctrl_pkg holds:
  - state encoding typedef (IDLE, RD_WAIT);
  - function for the strobe count (DATA_WIDTH/8);
  - READ_LATENCY legality bounds, checked at elaboration.
- One natural sub-module: reg_ctrl_lat_wmerge, a combinational byte-strobe merge (old, wdata, wstrb → new).
- The FSM, counter and storage stay in the top module.

Test Plan:
- Reset then idle → ready=1, rvalid=0, err=0, rdata=0; read addr 0 → rdata=16'h1234 with rvalid after 2 edges.
- Write addr 5 wdata=16'h01E2 wstrb=2'b11, read addr 5 on the next cycle → ready low for 2 cycles, then rvalid=1 with rdata=16'h01E2.
- Write addr 7 wdata=16'hABCD wstrb=2'b01, then read 7 → 16'h12CD; then wstrb=2'b10 wdata=16'hEF00 → reads 16'hEFCD.
- Read addr 3; while ready=0, drive a write addr 3 wdata=16'hFFFF → write is ignored; a later read of addr 3 returns 16'h1234.
- DEPTH=200: write addr 250 → err pulse at E0+1 and no entry changes; read addr 250 → rvalid=1, err=1, rdata=0 together.
- READ_LATENCY=1 and READ_LATENCY=8 builds: rvalid appears exactly 1 and 8 edges after accept; assert rst in the middle of a latency-8 read → no rvalid, ready=1 the cycle after reset, contents = 16'h1234.
